// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready handshake
// and multi-beat accumulate (reduction) mode.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [2:0]       ctrl_op,
  input  logic             ctrl_accum,
  input  logic             ctrl_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             result_zero,
  output logic             result_parity,
  output logic [7:0]       data_beats
);

  typedef enum logic {
    IDLE,
    ACC
  } state_t;

  localparam logic [2:0] OP_PASS = 3'b111;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       op_q, op_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       cnt_inc;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [7:0]       load_beats;
  logic [WIDTH-1:0] step_val;

  function automatic logic [WIDTH-1:0] logic_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] l,
    input logic [WIDTH-1:0] r
  );
    logic [WIDTH-1:0] y;
    case (op)
      3'b000:  y = l & r;
      3'b001:  y = l | r;
      3'b010:  y = l ^ r;
      3'b011:  y = ~(l | r);
      3'b100:  y = l & ~r;
      3'b101:  y = ~(l & r);
      3'b110:  y = ~(l ^ r);
      default: y = l;
    endcase
    return y;
  endfunction

  assign in_ready = reset && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

  // PASS inside a sequence forwards the newest beat, not the first one
  assign step_val = (op_q == OP_PASS) ? data_operandA
                  : logic_op(op_q, acc_q, data_operandA);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    load_val   = '0;
    load_beats = '0;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (!ctrl_accum) begin
            load       = 1'b1;
            load_val   = logic_op(ctrl_op, data_operandA, data_operandB);
            load_beats = 8'd1;
          end else begin
            acc_d = data_operandA;
            op_d  = ctrl_op;
            cnt_d = 8'd1;
            if (ctrl_last) begin
              load       = 1'b1;
              load_val   = data_operandA;
              load_beats = 8'd1;
            end else begin
              state_d = ACC;
            end
          end
        end
        ACC: begin
          if (ctrl_last) begin
            load       = 1'b1;
            load_val   = step_val;
            load_beats = cnt_inc;
            state_d    = IDLE;
          end else begin
            acc_d = step_val;
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // flags are derived from the value being loaded, never from stale data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid     <= 1'b0;
      data_result   <= '0;
      result_zero   <= 1'b0;
      result_parity <= 1'b0;
      data_beats    <= '0;
    end else if (load) begin
      out_valid     <= 1'b1;
      data_result   <= load_val;
      result_zero   <= (load_val == '0);
      result_parity <= ^load_val;
      data_beats    <= load_beats;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: 32- and 8-bit instances against a
// beat-list reference model, directed scenarios plus random traffic.
module tb_logic_unit_pipe;

  logic        clock;
  logic        reset;
  logic        iv    [2];
  logic [31:0] ia    [2];
  logic [31:0] ib    [2];
  logic [2:0]  iop   [2];
  logic        iacc  [2];
  logic        ilast [2];
  logic        ordy  [2];
  logic        ird   [2];
  logic        ov    [2];
  logic        rz    [2];
  logic        rp    [2];
  logic [7:0]  bts   [2];
  logic [31:0] res32;
  logic [7:0]  res8;
  logic [31:0] res   [2];

  int checks   = 0;
  int failures = 0;

  logic        mv    [2];
  logic [31:0] md    [2];
  logic        mz    [2];
  logic        mp    [2];
  logic [7:0]  mb    [2];
  logic        mopen [2];
  logic [2:0]  mop   [2];
  int          mn    [2];
  logic [31:0] mbeat [2][512];

  assign res[0] = res32;
  assign res[1] = {24'h0, res8};

  logic_unit_pipe #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset),
    .in_valid(iv[0]), .in_ready(ird[0]),
    .data_operandA(ia[0]), .data_operandB(ib[0]),
    .ctrl_op(iop[0]), .ctrl_accum(iacc[0]), .ctrl_last(ilast[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .data_result(res32), .result_zero(rz[0]),
    .result_parity(rp[0]), .data_beats(bts[0])
  );

  logic_unit_pipe #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset),
    .in_valid(iv[1]), .in_ready(ird[1]),
    .data_operandA(ia[1][7:0]), .data_operandB(ib[1][7:0]),
    .ctrl_op(iop[1]), .ctrl_accum(iacc[1]), .ctrl_last(ilast[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .data_result(res8), .result_zero(rz[1]),
    .result_parity(rp[1]), .data_beats(bts[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fop(input logic [2:0] op,
                                      input logic [31:0] l,
                                      input logic [31:0] r);
    case (op)
      3'd0:    return l & r;
      3'd1:    return l | r;
      3'd2:    return l ^ r;
      3'd3:    return ~(l | r);
      3'd4:    return l & ~r;
      3'd5:    return ~(l & r);
      3'd6:    return ~(l ^ r);
      default: return l;
    endcase
  endfunction

  function automatic logic [31:0] mask_of(input int k);
    return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction

  // fold the whole recorded beat list once the sequence closes
  function automatic logic [31:0] fold(input int k);
    int n;
    logic [31:0] r;
    n = (mn[k] > 512) ? 512 : mn[k];
    if (mop[k] == 3'd7) return mbeat[k][n-1];
    r = mbeat[k][0];
    for (int i = 1; i < n; i++)
      r = fop(mop[k], r, mbeat[k][i]) & mask_of(k);
    return r;
  endfunction

  task automatic mreset(input int k);
    mv[k] = 0; md[k] = 0; mz[k] = 0; mp[k] = 0; mb[k] = 0;
    mopen[k] = 0; mn[k] = 0; mop[k] = 0;
  endtask

  task automatic mstep(input int k);
    logic [31:0] m, a, b, r;
    logic ld;
    int nb;
    m = mask_of(k);
    a = ia[k] & m;
    b = ib[k] & m;
    ld = 0;
    r = 0;
    nb = 0;
    if (iv[k] && (!mv[k] || ordy[k])) begin
      if (!mopen[k]) begin
        if (!iacc[k]) begin
          r = fop(iop[k], a, b) & m; nb = 1; ld = 1;
        end else begin
          mop[k] = iop[k];
          mn[k] = 1;
          mbeat[k][0] = a;
          if (ilast[k]) begin
            r = a; nb = 1; ld = 1;
          end else mopen[k] = 1;
        end
      end else begin
        if (mn[k] < 512) mbeat[k][mn[k]] = a;
        mn[k]++;
        if (ilast[k]) begin
          r = fold(k);
          nb = (mn[k] > 255) ? 255 : mn[k];
          ld = 1;
          mopen[k] = 0;
        end
      end
    end
    if (ld) begin
      mv[k] = 1; md[k] = r; mz[k] = (r == 0); mp[k] = ^r;
      mb[k] = nb[7:0];
    end else if (ordy[k]) mv[k] = 0;
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mreset(0);
      mreset(1);
    end else begin
      mstep(0);
      mstep(1);
    end
  end

  always @(posedge clock) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("cmp%0d_in_ready", k), {31'b0, ird[k]},
          {31'b0, reset && (!mv[k] || ordy[k])});
      chk($sformatf("cmp%0d_out_valid", k), {31'b0, ov[k]}, {31'b0, mv[k]});
      if (mv[k] || !reset) begin
        chk($sformatf("cmp%0d_data", k), res[k], md[k]);
        chk($sformatf("cmp%0d_zero", k), {31'b0, rz[k]}, {31'b0, mz[k]});
        chk($sformatf("cmp%0d_parity", k), {31'b0, rp[k]}, {31'b0, mp[k]});
        chk($sformatf("cmp%0d_beats", k), {24'b0, bts[k]}, {24'b0, mb[k]});
      end
    end
  end

  task automatic beat(input int k, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic ac, input logic ls);
    int n;
    logic took;
    n = 0;
    took = 0;
    @(negedge clock);
    iv[k] = 1; ia[k] = a; ib[k] = b; iop[k] = op;
    iacc[k] = ac; ilast[k] = ls;
    while (!took && n < 50) begin
      #4;
      took = ird[k];
      @(posedge clock);
      n++;
      if (!took) @(negedge clock);
    end
    chk("beat_accept", {31'b0, took}, 32'd1);
  endtask

  task automatic settle(input int k);
    @(negedge clock);
    iv[k] = 0;
  endtask

  initial begin
    reset = 0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 0; ia[k] = 0; ib[k] = 0; iop[k] = 0;
      iacc[k] = 0; ilast[k] = 0; ordy[k] = 1;
    end
    iv[0] = 1;
    repeat (3) @(negedge clock);
    chk("rst_in_ready", {31'b0, ird[0]}, 0);
    chk("rst_out_valid", {31'b0, ov[0]}, 0);
    chk("rst_data", res[0], 0);
    chk("rst_zero", {31'b0, rz[0]}, 0);
    chk("rst_parity", {31'b0, rp[0]}, 0);
    chk("rst_beats", {24'b0, bts[0]}, 0);
    reset = 1;
    iv[0] = 0;
    #1 chk("rel_in_ready", {31'b0, ird[0]}, 1);
    @(negedge clock);
    chk("rel_no_result", {31'b0, ov[0]}, 0);

    beat(0, 32'hF0F0F0F0, 32'hFF00FF00, 3'd0, 0, 0);
    settle(0);
    chk("and_valid", {31'b0, ov[0]}, 1);
    chk("and_data", res[0], 32'hF000F000);
    chk("and_zero", {31'b0, rz[0]}, 0);
    chk("and_parity", {31'b0, rp[0]}, 0);
    chk("and_beats", {24'b0, bts[0]}, 1);
    beat(0, 32'hF0F0F0F0, 32'hFF00FF00, 3'd4, 0, 0);
    settle(0);
    chk("andn_data", res[0], 32'h00F000F0);

    beat(0, 32'h1, 32'h0, 3'd2, 1, 0);
    beat(0, 32'h2, 32'h0, 3'd0, 0, 0);
    settle(0);
    chk("acc_no_early", {31'b0, ov[0]}, 0);
    beat(0, 32'h4, 32'h0, 3'd0, 0, 1);
    settle(0);
    chk("acc_valid", {31'b0, ov[0]}, 1);
    chk("acc_data", res[0], 32'h7);
    chk("acc_parity", {31'b0, rp[0]}, 1);
    chk("acc_beats", {24'b0, bts[0]}, 3);
    @(negedge clock);
    chk("acc_single", {31'b0, ov[0]}, 0);

    ordy[0] = 0;
    beat(0, 32'hFF, 32'h0F, 3'd0, 0, 0);
    @(negedge clock);
    ia[0] = 32'h10; ib[0] = 32'h01; iop[0] = 3'd1;
    chk("bp_first", res[0], 32'h0F);
    #1 chk("bp_in_ready", {31'b0, ird[0]}, 0);
    repeat (5) begin
      @(negedge clock);
      chk("bp_hold_data", res[0], 32'h0F);
      chk("bp_hold_valid", {31'b0, ov[0]}, 1);
    end
    ordy[0] = 1;
    #1 chk("bp_release", {31'b0, ird[0]}, 1);
    settle(0);
    chk("bp_second_valid", {31'b0, ov[0]}, 1);
    chk("bp_second_data", res[0], 32'h11);
    chk("bp_second_beats", {24'b0, bts[0]}, 1);

    beat(0, 32'h8, 32'h0, 3'd1, 1, 0);
    beat(0, 32'h1, 32'h0, 3'd1, 1, 0);
    @(negedge clock);
    iv[0] = 0;
    reset = 0;
    @(negedge clock);
    chk("mid_rst_valid", {31'b0, ov[0]}, 0);
    reset = 1;
    beat(0, 32'h3, 32'h1, 3'd2, 0, 0);
    settle(0);
    chk("post_rst_data", res[0], 32'h2);
    chk("post_rst_beats", {24'b0, bts[0]}, 1);

    beat(1, 32'hFF, 32'h00, 3'd3, 0, 0);
    settle(1);
    chk("w8_nor_data", res[1], 32'h0);
    chk("w8_nor_zero", {31'b0, rz[1]}, 1);
    for (int i = 0; i < 300; i++)
      beat(1, 32'hFF, 32'h0, 3'd0, (i == 0), (i == 299));
    settle(1);
    chk("w8_sat_valid", {31'b0, ov[1]}, 1);
    chk("w8_sat_beats", {24'b0, bts[1]}, 255);
    chk("w8_sat_data", res[1], 32'hFF);
    chk("w8_sat_parity", {31'b0, rp[1]}, 0);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 399) != 0);
      for (int k = 0; k < 2; k++) begin
        iv[k]    = ($urandom_range(0, 3) != 0);
        ia[k]    = $urandom;
        ib[k]    = $urandom;
        iop[k]   = 3'($urandom_range(0, 7));
        iacc[k]  = $urandom_range(0, 1) == 1;
        ilast[k] = ($urandom_range(0, 3) == 0);
        ordy[k]  = ($urandom_range(0, 3) != 0);
      end
    end
    @(negedge clock);
    reset = 1;
    iv[0] = 0;
    iv[1] = 0;
    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
